// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length header followed by little-endian
// instruction bytes and emits one write strobe per assembled 32-bit word.
module imem_loader #(
  parameter int NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        WE,
  output logic [7:0]  WA,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_LEN   | waiting for the word-count header byte
  // S_RECV  | assembling instruction bytes into a word
  // S_WRITE | single-cycle write strobe for the assembled word
  // S_DONE  | all words written, waiting for start
  // S_ERR   | header was zero or too large, waiting for start
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [8:0] MAX_N = 9'(NUM_WORDS);

  state_t      state_q;
  logic [7:0]  len_q;
  logic [7:0]  idx_q;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] word_d;
  logic        ready_q;
  logic        we_q;
  logic [7:0]  wa_q;
  logic [31:0] wd_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic        accept;

  assign accept = byte_valid & ready_q;

  // The incoming byte lands in the lane selected by the running byte count.
  always_comb begin
    word_d = word_q;
    word_d[{cnt_q, 3'b000} +: 8] = byte_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 8'h00;
      idx_q   <= 8'h00;
      cnt_q   <= 2'd0;
      word_q  <= 32'h0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= 8'h00;
      wd_q    <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q <= S_LEN;
            idx_q   <= 8'h00;
            cnt_q   <= 2'd0;
            word_q  <= 32'h0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if ((byte_in == 8'h00) || ({1'b0, byte_in} > MAX_N)) begin
              state_q <= S_ERR;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              len_q   <= byte_in;
              state_q <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (accept) begin
            word_q <= word_d;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              // Stop accepting while the strobe is out so no byte slips past.
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              wa_q    <= idx_q << 2;
              wd_q    <= word_d;
            end
          end
        end
        S_WRITE: begin
          if (idx_q == (len_q - 8'd1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= S_RECV;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = ready_q;
  assign WE         = we_q;
  assign WA         = wa_q;
  assign WD         = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a transaction-level model predicts the
// write sequence and status flags, checked every cycle on the falling edge.
module tb_imem_loader;

  typedef struct {
    logic [7:0]  wa;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        WE;
  logic [7:0]  WA;
  logic [31:0] WD;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.NUM_WORDS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .WE         (WE),
    .WA         (WA),
    .WD         (WD),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of what the outputs must be during the current cycle.
  bit          monitor_on = 1'b0;
  bit          m_busy, m_done, m_err, m_we_due;
  int          m_words_left;
  logic [7:0]  m_last_wa;
  logic [31:0] m_last_wd;
  wr_t         exp_q[$];
  wr_t         log_q[$];

  logic [31:0] ref_wd [6] = '{32'h00100193, 32'h0ff00083, 32'h0011f133,
                              32'h003122b3, 32'h0e500fa3, 32'hfe0008e3};
  logic [7:0]  ref_stream[$] = '{8'h06,
    8'h93, 8'h01, 8'h10, 8'h00,  8'h83, 8'h00, 8'hF0, 8'h0F,
    8'h33, 8'hF1, 8'h11, 8'h00,  8'hB3, 8'h22, 8'h31, 8'h00,
    8'hA3, 8'h0F, 8'h50, 8'h0E,  8'hE3, 8'h08, 8'h00, 8'hFE};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_we_due = 0;
    m_words_left = 0;
    m_last_wa = 8'h00; m_last_wd = 32'h0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (monitor_on) begin
      wr_t e;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("byte_ready", 32'(byte_ready), 32'(m_busy && !m_we_due));
      chk("WE", 32'(WE), 32'(m_we_due));
      if (WE) log_q.push_back('{WA, WD});
      if (m_we_due) begin
        e = exp_q.pop_front();
        if (WE) begin
          chk("WA", 32'(WA), 32'(e.wa));
          chk("WD", WD, e.wd);
        end
        m_last_wa = e.wa;
        m_last_wd = e.wd;
        m_we_due = 0;
        m_words_left--;
        if (m_words_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        chk("WA hold", 32'(WA), 32'(m_last_wa));
        chk("WD hold", WD, m_last_wd);
      end
    end
  end

  // One clock: inputs already driven; returns whether a byte was consumed.
  task automatic step(output bit acc);
    bit rdy, v, s, r, sb;
    rdy = byte_ready; v = byte_valid; s = start; r = rst_n; sb = m_busy;
    @(posedge clk);
    #1;
    acc = r && v && rdy;
    if (!r) model_reset();
    else if (s && !sb) begin
      m_busy = 1; m_done = 0; m_err = 0; m_we_due = 0;
      m_words_left = 0;
    end
  endtask

  // gap_mode: 0 = valid held high, >0 = that many idle cycles before each byte,
  // <0 = random 0..-gap_mode idle cycles. start_at/reset_at = byte index or -1.
  task automatic session(input logic [7:0] bytes[$], input int gap_mode,
                         input int start_at, input int reset_at);
    bit acc;
    int bound, g;
    logic [31:0] w;
    int log_before;
    log_before = log_q.size();
    w = 32'h0;
    start = 1; step(acc); start = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      g = (gap_mode >= 0) ? gap_mode : int'($urandom_range(-gap_mode, 0));
      for (int k = 0; k < g; k++) begin
        byte_valid = 0; byte_in = 8'($urandom); step(acc);
      end
      byte_in = bytes[i];
      byte_valid = 1;
      if (i == reset_at) begin
        rst_n = 0; start = 1; step(acc);
        rst_n = 1; start = 0; byte_valid = 0;
        return;
      end
      acc = 0; bound = 0;
      while (!acc && bound < 16) begin
        if (i == start_at && bound == 0) start = 1;
        step(acc);
        start = 0;
        bound++;
      end
      if (!acc) begin
        n_cmp++; n_bad++;
        $display("FAIL byte accept timeout: byte %0d not taken within 16 cycles", i);
        byte_valid = 0;
        return;
      end
      if (i == 0) begin
        if (bytes[0] == 8'h00 || bytes[0] > 8'd64) begin
          m_err = 1; m_busy = 0;
          break;
        end
        m_words_left = int'(bytes[0]);
      end else begin
        w[8*((i-1)%4) +: 8] = bytes[i];
        if ((i-1) % 4 == 3) begin
          exp_q.push_back('{8'(4*((i-1)/4)), w});
          m_we_due = 1;
        end
      end
      if (gap_mode != 0) byte_valid = 0;
    end
    byte_valid = 0;
    bound = 0;
    while (m_busy && bound < 20) begin step(acc); bound++; end
    if (m_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL session end timeout: still expecting busy after 20 cycles");
    end
    chk("write count", 32'(log_q.size() - log_before),
        (bytes[0] == 8'h00 || bytes[0] > 8'd64) ? 32'h0 : 32'(bytes[0]));
  endtask

  task automatic check_ref_log(input int from, input string tag);
    chk({tag, " n"}, 32'(log_q.size() - from), 32'd6);
    for (int i = 0; i < 6 && from + i < log_q.size(); i++) begin
      chk({tag, " WA"}, 32'(log_q[from+i].wa), 32'(4*i));
      chk({tag, " WD"}, log_q[from+i].wd, ref_wd[i]);
    end
  endtask

  function automatic void make_stream(output logic [7:0] s[$], input logic [7:0] hdr, input int nw);
    s.delete();
    s.push_back(hdr);
    for (int i = 0; i < 4*nw; i++) s.push_back(8'($urandom));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int from, sel, nw;
    logic [7:0] s[$];
    logic [7:0] hdr;

    rst_n = 0; start = 1; byte_valid = 1; byte_in = 8'h05;
    step(acc); step(acc);
    rst_n = 1; start = 0; byte_valid = 0;
    model_reset();
    monitor_on = 1;
    chk("reset WA", 32'(WA), 32'h0);
    chk("reset WD", WD, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    step(acc);

    from = log_q.size();
    session(ref_stream, 0, -1, -1);
    check_ref_log(from, "ref stream");
    chk("ref done", 32'(done), 32'h1);

    session('{8'h00, 8'h11}, 0, -1, -1);
    chk("zero len error", 32'(error), 32'h1);
    from = log_q.size();
    session('{8'h01, 8'h78, 8'h56, 8'h34, 8'h12}, 0, -1, -1);
    chk("single WD", (log_q.size() > from) ? log_q[from].wd : 32'hx, 32'h12345678);
    chk("single done", 32'(done), 32'h1);

    session('{8'h41, 8'h00}, 0, -1, -1);
    chk("len65 error", 32'(error), 32'h1);
    chk("len65 ready", 32'(byte_ready), 32'h0);

    from = log_q.size();
    session(ref_stream, 3, -1, -1);
    check_ref_log(from, "gapped stream");

    from = log_q.size();
    session('{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0, -1, 3);
    chk("mid reset WA", 32'(WA), 32'h0);
    chk("mid reset WD", WD, 32'h0);
    chk("mid reset done", 32'(done), 32'h0);
    for (int k = 0; k < 3; k++) step(acc);
    chk("mid reset no WE", 32'(log_q.size() - from), 32'h0);
    session('{8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 0, -1, -1);
    chk("post reset WA", 32'(log_q[log_q.size()-1].wa), 32'h0);
    chk("post reset WD", log_q[log_q.size()-1].wd, 32'h04030201);

    from = log_q.size();
    session(ref_stream, 0, 7, -1);
    check_ref_log(from, "start while busy");

    make_stream(s, 8'd64, 64);
    session(s, 0, 100, -1);

    for (int t = 0; t < 30; t++) begin
      sel = int'($urandom_range(9, 0));
      case (sel)
        0: begin hdr = 8'h00; nw = 1; end
        1: begin hdr = 8'($urandom_range(255, 65)); nw = 1; end
        2: begin hdr = 8'd64; nw = 64; end
        default: begin nw = int'($urandom_range(6, 1)); hdr = 8'(nw); end
      endcase
      make_stream(s, hdr, nw);
      session(s, ($urandom_range(1, 0) == 1) ? -int'($urandom_range(4, 1)) : 0,
              int'($urandom_range(4*nw, 1)),
              ($urandom_range(9, 0) == 0) ? int'($urandom_range(4*nw, 1)) : -1);
      for (int k = 0; k < int'($urandom_range(3, 0)); k++) step(acc);
    end

    step(acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
